// File: rtl/cbus_rr_arbiter_pkg.sv
// ============================================================================
// Module  : cbus_rr_arbiter_pkg
// Brief   : Shared CBus request/response types, arbiter state and segment constants
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cbus_rr_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [3:0]  strobe;
        logic [31:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam logic [3:0]  KSEG0_HI = 4'h8;
    localparam logic [3:0]  KSEG1_HI = 4'hA;
    localparam logic [31:0] SEG_MASK = 32'h1FFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/cbus_rr_arbiter_seg_translate.sv
// ============================================================================
// Module  : seg_translate
// Brief   : kseg0/kseg1 virtual-to-physical address translation and uncached flag
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_translate
    import cbus_rr_arbiter_pkg::*;
(
    input  logic [31:0] vaddr,
    output logic [31:0] paddr,
    output logic        uncached
);

    logic [3:0] w_seg;
    logic       w_in_kseg;

    assign w_seg     = vaddr[31:28];
    // kseg0 and kseg1 together span segment nibbles 0x8..0xB
    assign w_in_kseg = (w_seg >= KSEG0_HI) && (w_seg <= (KSEG1_HI | 4'h1));
    assign paddr     = w_in_kseg ? (vaddr & SEG_MASK) : vaddr;
    assign uncached  = (vaddr[31:29] == KSEG1_HI[3:1]);

endmodule

`default_nettype wire

// File: rtl/cbus_rr_arbiter.sv
// ============================================================================
// Module  : cbus_rr_arbiter
// Brief   : N-port CBus arbiter, fixed-priority or round-robin, burst-locked grant
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int RR         = 1,
    parameter int TRANSLATE  = 1
) (
    input  logic                                       clk,
    input  logic                                       resetn,
    input  cbus_req_t  [NUM_INPUTS-1:0]                ireqs,
    output cbus_resp_t [NUM_INPUTS-1:0]                iresps,
    output cbus_req_t                                  oreq,
    input  cbus_resp_t                                 oresp,
    output logic       [$clog2(NUM_INPUTS)-1:0]        grant,
    output logic                                       busy,
    output logic                                       uncached
);

    localparam int c_GW = $clog2(NUM_INPUTS);
    localparam logic [c_GW-1:0] c_LAST_IDX = c_GW'(NUM_INPUTS - 1);

    arb_state_t            r_state_q, w_state_d;
    logic [c_GW-1:0]       r_grant_q, w_grant_d;
    logic [c_GW-1:0]       r_rr_ptr_q, w_rr_ptr_d;
    logic [NUM_INPUTS-1:0] w_valids;
    cbus_req_t             w_owner_req;
    logic [31:0]           w_seg_paddr;
    logic                  w_seg_uncached;

    // First requester at or after 'start', wrapping modulo NUM_INPUTS.
    function automatic logic [c_GW-1:0] pick_first(input logic [NUM_INPUTS-1:0] req,
                                                   input logic [c_GW-1:0]       start);
        logic [c_GW-1:0]       sel;
        logic [NUM_INPUTS-1:0] shifted;
        int                    idx;
        sel = '0;
        for (int off = NUM_INPUTS - 1; off >= 0; off--) begin
            idx     = (int'(start) + off) % NUM_INPUTS;
            shifted = req >> idx;
            if (shifted[0]) begin
                sel = c_GW'(idx);
            end
        end
        return sel;
    endfunction

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_valid
        assign w_valids[gi] = ireqs[gi].valid;
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_grant_d  = r_grant_q;
        w_rr_ptr_d = r_rr_ptr_q;
        case (r_state_q)
            IDLE: begin
                if (|w_valids) begin
                    w_state_d = BUSY;
                    w_grant_d = pick_first(w_valids, (RR != 0) ? r_rr_ptr_q : '0);
                end
            end
            BUSY: begin
                if (oresp.ready && oresp.last) begin
                    w_state_d = IDLE;
                    if (RR != 0) begin
                        w_rr_ptr_d = (r_grant_q == c_LAST_IDX) ? '0 : r_grant_q + 1'b1;
                    end
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_q  <= IDLE;
            r_grant_q  <= '0;
            r_rr_ptr_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_grant_q  <= w_grant_d;
            r_rr_ptr_q <= w_rr_ptr_d;
        end
    end

    assign w_owner_req = ireqs[r_grant_q];

    seg_translate u_seg_translate (
        .vaddr    (w_owner_req.addr),
        .paddr    (w_seg_paddr),
        .uncached (w_seg_uncached)
    );

    // Owner request is forwarded combinationally so per-beat data/strobe see no delay
    always_comb begin
        oreq   = '0;
        iresps = '0;
        if (r_state_q == BUSY) begin
            oreq                = w_owner_req;
            oreq.addr           = (TRANSLATE != 0) ? w_seg_paddr : w_owner_req.addr;
            iresps[r_grant_q]   = oresp;
        end
    end

    assign busy     = (r_state_q == BUSY);
    assign grant    = r_grant_q;
    assign uncached = busy & w_seg_uncached;

endmodule

`default_nettype wire

// File: tb/tb_cbus_rr_arbiter.sv
// ============================================================================
// Module  : tb_cbus_rr_arbiter
// Brief   : Scoreboard bench for cbus_rr_arbiter (RR+translate and fixed-priority pass-through)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cbus_rr_arbiter;
    import cbus_rr_arbiter_pkg::*;

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic        unc;
        bit          chk_unc;
        int          len;
        int          gap;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   sel, resetn_a, resetn_b, resetn_cur;
    cbus_req_t  [3:0]       ireqs;
    cbus_resp_t             oresp, oresp_a, oresp_b;
    cbus_resp_t [3:0]       iresps, iresps_a, iresps_b;
    cbus_req_t              oreq, oreq_a, oreq_b;
    logic       [1:0]       grant, grant_a, grant_b;
    logic                   busy, busy_a, busy_b, uncached, unc_a, unc_b;

    cbus_rr_arbiter #(.NUM_INPUTS(4), .RR(1), .TRANSLATE(1)) u_dut_rr (
        .clk(clk), .resetn(resetn_a), .ireqs(ireqs), .iresps(iresps_a), .oreq(oreq_a),
        .oresp(oresp_a), .grant(grant_a), .busy(busy_a), .uncached(unc_a)
    );

    cbus_rr_arbiter #(.NUM_INPUTS(4), .RR(0), .TRANSLATE(0)) u_dut_fp (
        .clk(clk), .resetn(resetn_b), .ireqs(ireqs), .iresps(iresps_b), .oreq(oreq_b),
        .oresp(oresp_b), .grant(grant_b), .busy(busy_b), .uncached(unc_b)
    );

    assign resetn_cur = sel ? resetn_b : resetn_a;
    always_comb begin
        oresp_a  = sel ? '0 : oresp;
        oresp_b  = sel ? oresp : '0;
        oreq     = sel ? oreq_b : oreq_a;
        iresps   = sel ? iresps_b : iresps_a;
        grant    = sel ? grant_b : grant_a;
        busy     = sel ? busy_b : busy_a;
        uncached = sel ? unc_b : unc_a;
    end

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cnt[4];
    logic [31:0] addr_p[4];
    logic [3:0]  len_p[4];
    int          beat[4];
    bit          hs_rdy[4], hs_lst[4];
    int          mem_beat;
    bit          mem_hs, mem_lst, mem_force, in_tx;

    function automatic logic [31:0] beat_data(int p, int b);
        return 32'hD000_0000 | (32'(p) << 8) | 32'(b);
    endfunction

    function automatic logic [3:0] beat_strobe(int b);
        return 4'b0001 << (b % 4);
    endfunction

    task automatic check_eq(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0; beat[i] = 0; hs_rdy[i] = 0; hs_lst[i] = 0;
        end
        mem_beat = 0; mem_hs = 0; mem_lst = 0;
    endtask

    task automatic req(int p, logic [31:0] a, int len, int n);
        addr_p[p] = a;
        len_p[p]  = 4'(len);
        cnt[p]    = n;
    endtask

    task automatic expect_tx(int p, logic [31:0] a, logic u, bit cu, int len, int gap);
        exp_t e;
        e.port = p; e.addr = a; e.unc = u; e.chk_unc = cu; e.len = len; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(int budget, string name);
        bit done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            @(posedge clk); #1;
            done = (exp_q.size() == 0) && !in_tx && ((cnt[0] + cnt[1] + cnt[2] + cnt[3]) == 0);
        end
        check_eq(name, 32'(done), 1);
    endtask

    task automatic wait_beat(int p, int b, int budget, string name);
        bit done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            @(posedge clk); #1;
            done = (beat[p] == b);
        end
        check_eq(name, 32'(done), 1);
    endtask

    // Requesters and an always-ready memory: handshakes seen before an edge are applied at the next negedge
    initial begin
        clear_model();
        mem_force = 0;
        ireqs     = '0;
        oresp     = '0;
        for (int i = 0; i < 4; i++) begin addr_p[i] = '0; len_p[i] = '0; end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (hs_rdy[i]) begin
                    if (hs_lst[i]) begin
                        beat[i] = 0;
                        if (cnt[i] > 0) cnt[i]--;
                    end else begin
                        beat[i]++;
                    end
                end
            end
            if (mem_hs) mem_beat = mem_lst ? 0 : mem_beat + 1;
            for (int i = 0; i < 4; i++) begin
                ireqs[i]          = '0;
                ireqs[i].valid    = (cnt[i] > 0);
                ireqs[i].is_write = (len_p[i] != 0);
                ireqs[i].size     = 3'd2;
                ireqs[i].addr     = addr_p[i];
                ireqs[i].len      = len_p[i];
                ireqs[i].strobe   = beat_strobe(beat[i]);
                ireqs[i].data     = beat_data(i, beat[i]);
            end
            #1;
            oresp = '0;
            if (mem_force) begin
                oresp.ready = 1'b1; oresp.last = 1'b1; oresp.data = 32'hDEAD_BEEF;
            end else if (busy && oreq.valid) begin
                oresp.ready = 1'b1;
                oresp.last  = (mem_beat == int'(oreq.len));
                oresp.data  = 32'h5A00_0000 | 32'(mem_beat);
            end
            mem_hs  = oresp.ready && busy;
            mem_lst = oresp.last;
            #1;
            for (int i = 0; i < 4; i++) begin
                hs_rdy[i] = iresps[i].ready;
                hs_lst[i] = iresps[i].last;
            end
        end
    end

    // Monitor: pops one expectation per new grant, then checks every beat until last
    initial begin
        exp_t cur;
        int   gap   = 0;
        int   beats = 0;
        in_tx = 0;
        cur.port = 0; cur.addr = '0; cur.unc = 0; cur.chk_unc = 0; cur.len = 0; cur.gap = -1;
        forever begin
            @(negedge clk); #3;
            if (resetn_cur !== 1'b1) begin
                in_tx = 0; gap = 0;
                continue;
            end
            if (!busy) begin
                gap++;
                check_eq("idle_oreq", 32'(oreq != '0), 0);
                check_eq("idle_iresps", 32'(iresps != '0), 0);
                check_eq("idle_uncached", 32'(uncached), 0);
            end else begin
                if (!in_tx) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_grant", 32'(grant), 32'hFFFF_FFFF);
                        cur.port = int'(grant); cur.addr = oreq.addr; cur.chk_unc = 0;
                        cur.len = int'(oreq.len); cur.gap = -1;
                    end else begin
                        cur = exp_q.pop_front();
                        check_eq("grant_order", 32'(grant), 32'(cur.port));
                        if (cur.gap >= 0) check_eq("bubble", 32'(gap), 32'(cur.gap));
                        if (cur.chk_unc) check_eq("uncached", 32'(uncached), 32'(cur.unc));
                    end
                    in_tx = 1; beats = 0;
                end
                check_eq("grant_lock", 32'(grant), 32'(cur.port));
                check_eq("oreq_valid", 32'(oreq.valid), 1);
                check_eq("oreq_addr", oreq.addr, cur.addr);
                check_eq("oreq_data", oreq.data, beat_data(cur.port, beats));
                check_eq("oreq_strobe", 32'(oreq.strobe), 32'(beat_strobe(beats)));
                for (int j = 0; j < 4; j++) begin
                    if (j == cur.port) check_eq("iresp_route", 32'(iresps[j] != oresp), 0);
                    else               check_eq("iresp_other", 32'(iresps[j] != '0), 0);
                end
                if (iresps[cur.port].ready) begin
                    beats++;
                    if (iresps[cur.port].last) begin
                        check_eq("beat_count", 32'(beats), 32'(cur.len + 1));
                        in_tx = 0; gap = 0;
                    end
                end
            end
        end
    end

    initial begin
        sel = 0; resetn_a = 0; resetn_b = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_grant", 32'(grant), 0);
        check_eq("rst_oreq_valid", 32'(oreq.valid), 0);
        resetn_a = 1;
        repeat (10) @(posedge clk);
        #1;
        mem_force = 1;
        repeat (3) @(posedge clk);
        #1;
        mem_force = 0;
        check_eq("stray_resp_busy", 32'(busy), 0);

        // Round-robin fairness, single-beat, port 0 comes back for a second round
        expect_tx(0, 32'h0000_0100, 1'b0, 1, 0, -1);
        expect_tx(1, 32'h0000_0200, 1'b0, 1, 0, 1);
        expect_tx(2, 32'h0000_0300, 1'b0, 1, 0, 1);
        expect_tx(3, 32'h0000_0400, 1'b0, 1, 0, 1);
        expect_tx(0, 32'h0000_0100, 1'b0, 1, 0, 1);
        req(0, 32'h0000_0100, 0, 2);
        req(1, 32'h0000_0200, 0, 1);
        req(2, 32'h0000_0300, 0, 1);
        req(3, 32'h0000_0400, 0, 1);
        wait_idle(80, "rr_round_done");

        // rr_ptr is 1: port 2 burst wins over port 0, then port 0 (kseg1)
        expect_tx(2, 32'h0000_1000, 1'b0, 1, 3, -1);
        expect_tx(0, 32'h1FC0_0000, 1'b1, 1, 0, 1);
        req(2, 32'h8000_1000, 3, 1);
        req(0, 32'hBFC0_0000, 0, 1);
        wait_idle(80, "burst_lock_done");

        expect_tx(1, 32'h0040_0000, 1'b0, 1, 0, -1);
        req(1, 32'h0040_0000, 0, 1);
        wait_idle(40, "kuseg_done");

        // rr_ptr is 2 here; abandon a port 3 burst, after reset port 1 must beat port 3
        expect_tx(3, 32'h0000_2000, 1'b1, 1, 3, -1);
        req(3, 32'hA000_2000, 3, 1);
        wait_beat(3, 1, 30, "rst_mid_reach");
        resetn_a = 0;
        clear_model();
        #1;
        check_eq("rst_mid_valid", 32'(oreq.valid), 0);
        check_eq("rst_mid_busy", 32'(busy), 0);
        @(posedge clk); #1;
        resetn_a = 1;
        expect_tx(1, 32'h0000_0500, 1'b0, 1, 0, -1);
        expect_tx(3, 32'h0000_0600, 1'b0, 1, 0, 1);
        req(1, 32'h0000_0500, 0, 1);
        req(3, 32'h0000_0600, 0, 1);
        wait_idle(40, "post_rst_done");

        // Fixed priority, no translation
        resetn_a = 0;
        sel      = 1;
        clear_model();
        @(posedge clk); #1;
        resetn_b = 1;
        repeat (2) @(posedge clk);
        #1;
        expect_tx(1, 32'h0000_0700, 1'b0, 0, 2, -1);
        expect_tx(0, 32'h0000_0800, 1'b0, 0, 0, 1);
        expect_tx(3, 32'h0000_0900, 1'b0, 0, 0, 1);
        req(1, 32'h0000_0700, 2, 1);
        req(3, 32'h0000_0900, 0, 1);
        wait_beat(1, 1, 30, "fp_mid_reach");
        req(0, 32'h0000_0800, 0, 1);
        wait_idle(60, "fixed_prio_done");

        expect_tx(2, 32'hBFC0_0000, 1'b0, 0, 0, -1);
        req(2, 32'hBFC0_0000, 0, 1);
        wait_idle(40, "passthru_done");

        check_eq("queue_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/cbus_rr_arbiter.md
# cbus_rr_arbiter

Parametrised N-port CBus arbiter for the memory side of the CPU top level. It replaces the fixed 4-input mux that merges cached and uncached instruction and data traffic onto the single external `cbus`. It adds selectable fixed-priority or round-robin arbitration, grant locking across a whole burst, and optional kseg0/kseg1 virtual-to-physical translation of the outgoing address. It sits between the cache/bus-converter instances and the top-level `oreq`/`oresp` ports.

## Interface
- `NUM_INPUTS`, default 4: number of requesting CBus ports, 2..8.
- `RR`, default 1: 1 = round-robin, 0 = fixed priority (index 0 highest).
- `TRANSLATE`, default 1: 1 = apply segment translation to `oreq.addr`; 0 = pass the address through.
- `clk`, in, 1: clock. One clock domain only.
- `resetn`, in, 1: reset, asynchronous and active-low.
- `ireqs`, in, `NUM_INPUTS` x `cbus_req_t`: requests; port i is `ireqs[i]`.
- `iresps`, out, `NUM_INPUTS` x `cbus_resp_t`: responses, one per port.
- `oreq`, out, `cbus_req_t`: request to memory.
- `oresp`, in, `cbus_resp_t`: response from memory.
- `grant`, out, `$clog2(NUM_INPUTS)`: index of the current owner. Valid only while `busy`=1.
- `busy`, out, 1: a transaction is in flight.
- `uncached`, out, 1: the current owner's address is in kseg1 (0xA/0xB). Valid while `busy`=1.

## Operation
- FSM with two states.
  - IDLE: `oreq` = 0 and all `iresps` = 0.
  - BUSY: the owner index is held in `grant`.
- IDLE → BUSY when any `ireqs[i].valid` = 1.
  - Fixed priority picks the lowest valid index.
  - Round-robin picks the first valid index at or after `rr_ptr`, wrapping modulo `NUM_INPUTS`.
  - The chosen index is registered into `grant`.
- In BUSY:
  - `oreq` = `ireqs[grant]`, forwarded combinationally, so write-burst data and strobe changes per beat propagate with zero latency.
  - `iresps[grant]` = `oresp`; every other `iresps[j]` = 0.
- BUSY → IDLE when `oresp.ready && oresp.last`.
  - Round-robin only: on that same edge, `rr_ptr` ← `grant`+1, wrapping to 0 after `NUM_INPUTS`-1.
  - `rr_ptr` does not move in fixed-priority mode.
- No preemption. A request that arrives while BUSY waits, however high its priority.
- Requesters must hold `valid` until `last`. The grant stays locked even if the owner drops `valid`; `oreq.valid` then follows the owner's value.
- Translation, applied when `TRANSLATE`=1, on `addr[31:28]`:
  - 0x8–0xB → `paddr = {3'b000, addr[28:0]}`.
  - All other values → `paddr = addr`.
  - `uncached` = (`addr[31:29]` == 3'b101), computed from the untranslated owner address.
- All other `oreq` fields are passed unchanged.

## Timing
- Reset values:
  - state = IDLE, `grant` = 0, `rr_ptr` = 0, `busy` = 0.
  - `oreq` = 0 and all `iresps` = 0.
  - `uncached` = 0 (it is qualified by `busy`).
- Arbitration latency is 1 cycle. `valid` seen in IDLE at edge k means `oreq.valid` = 1 from cycle k+1.
- Back-to-back transactions: the last beat completes at edge k, the state returns to IDLE, and the next grant is registered at edge k+1. This gives exactly one idle bubble cycle on `oreq`.
- Simultaneous requests are resolved in the single IDLE cycle. The losers keep `valid` asserted and are served in later rounds.
- Single-beat transaction (`len` = 0): `last` arrives together with the first `ready`; BUSY lasts until that edge.
- `resetn` deasserted mid-burst:
  - Immediately and asynchronously: `oreq.valid` = 0 and `busy` = 0.
  - The in-flight transaction is abandoned; the memory side is reset with the same `resetn`.
- An `oresp` received in IDLE is ignored and is not routed to any port.

## Structure
- The shared bus package (already holding `cbus_req_t`/`cbus_resp_t`) gains:
  - state enum `arb_state_t` {IDLE, BUSY};
  - constants `KSEG0_HI` = 4'h8, `KSEG1_HI` = 4'hA, `SEG_MASK` = 32'h1FFF_FFFF.
- One sub-module: `seg_translate`, combinational, with ports `vaddr`→`paddr` and `uncached`. It is instantiated once on the owner's address.
- The priority/round-robin pick is a local function inside the arbiter, not a separate module.

## Test plan
- Reset then idle: hold `resetn`=0, then release, with no requests → `oreq.valid`=0, `busy`=0 and all `iresps`=0 for 10 cycles.
- Round-robin fairness (`RR`=1, N=4): all four ports assert `valid` continuously with `len`=0 → grant order 0,1,2,3,0. One bubble between grants. Each port sees exactly one `ready` per round.
- Fixed priority (`RR`=0): ports 1 and 3 both request → port 1 is served first. Port 0 requests mid-transaction → port 0 is served before port 3, with no preemption of port 1.
- Burst lock: port 2 sends a 4-beat write with `addr`=0x8000_1000 while port 0 requests → `oreq.addr`=0x0000_1000. The grant stays 2 through 4 beats of changing `data`/`strobe` until `last`; port 0 is granted next.
- Translation and uncached flag: `addr`=0xBFC0_0000 → `paddr`=0x1FC0_0000, `uncached`=1. `addr`=0x0040_0000 → unchanged, `uncached`=0. With `TRANSLATE`=0, 0xBFC0_0000 passes through unchanged.
- Reset mid-burst: drop `resetn` on beat 2 of 4 → `oreq.valid`=0 the same cycle. After release, a new request is granted normally and `rr_ptr` = 0.
